// File: rtl/mealy_table_fsm.sv
// Run-time programmable Mealy machine: the transition/output table is a register
// file written and read through a config port, with a step counter and sticky error.
module mealy_table_fsm #(
  parameter int N_STATES = 4,
  parameter int IN_W     = 2,
  parameter int OUT_W    = 1,
  parameter int CNT_W    = 16,
  localparam int SW      = (N_STATES > 2) ? $clog2(N_STATES) : 1,
  localparam int AW      = SW + IN_W,
  localparam int DW      = SW + OUT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IN_W-1:0]  sw_in,
  input  logic             ctrl_in,
  input  logic [SW-1:0]    state_in,
  input  logic             cfg_we,
  input  logic             cfg_re,
  input  logic [AW-1:0]    cfg_addr,
  input  logic [DW-1:0]    cfg_wdata,
  output logic [DW-1:0]    cfg_rdata,
  output logic             cfg_rvalid,
  input  logic             err_clr,
  output logic [SW-1:0]    state,
  output logic [OUT_W-1:0] out,
  output logic [CNT_W-1:0] step_cnt,
  output logic             err
);

  localparam int DEPTH = 1 << AW;

  // Entries are {next_state, out}; addresses are {state, input}.
  logic [DW-1:0] tbl [DEPTH];

  logic [DW-1:0] step_entry;
  logic [SW-1:0] step_next;
  logic          step_legal;
  logic          addr_legal;
  logic          reset_legal;
  logic          err_set;

  always_comb begin
    step_entry  = tbl[{state, sw_in}];
    step_next   = step_entry[DW-1:OUT_W];
    step_legal  = int'(step_next) < N_STATES;
    addr_legal  = int'(cfg_addr[AW-1:IN_W]) < N_STATES;
    reset_legal = int'(state_in) < N_STATES;
    err_set     = ((cfg_we || cfg_re) && !addr_legal) || (ctrl_in && !step_legal);
  end

  // Step, read and write all sample the table before this edge's write lands.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= reset_legal ? state_in : '0;
      out        <= '0;
      step_cnt   <= '0;
      cfg_rdata  <= '0;
      cfg_rvalid <= 1'b0;
      err        <= !reset_legal;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        tbl[AW'(i)] <= '0;
      end
    end else begin
      if (ctrl_in) begin
        state    <= step_legal ? step_next : '0;
        out      <= step_entry[OUT_W-1:0];
        step_cnt <= step_cnt + CNT_W'(1);
      end
      cfg_rvalid <= cfg_re;
      if (cfg_re) begin
        cfg_rdata <= addr_legal ? tbl[cfg_addr] : '0;
      end
      if (cfg_we && addr_legal) begin
        tbl[cfg_addr] <= cfg_wdata;
      end
      if (err_set) begin
        err <= 1'b1;
      end else if (err_clr) begin
        err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mealy_table_fsm.sv
// Drives a default instance and an N_STATES=3/CNT_W=3 instance with identical
// stimulus and compares both against a table-level behavioural model every cycle.
module tb_mealy_table_fsm;

  logic       clk = 1'b0;
  logic       reset, ctrl_in, cfg_we, cfg_re, err_clr;
  logic [1:0] sw_in, state_in;
  logic [3:0] cfg_addr;
  logic [2:0] cfg_wdata;

  logic [2:0]  rd0, rd1;
  logic        rv0, rv1, err0, err1;
  logic [1:0]  st0, st1;
  logic        out0, out1;
  logic [15:0] cnt0;
  logic [2:0]  cnt1;

  int total = 0;
  int bad   = 0;
  bit started = 0;

  always #5 clk = ~clk;

  mealy_table_fsm u_dut (
    .clk(clk), .reset(reset), .sw_in(sw_in), .ctrl_in(ctrl_in), .state_in(state_in),
    .cfg_we(cfg_we), .cfg_re(cfg_re), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .cfg_rdata(rd0), .cfg_rvalid(rv0), .err_clr(err_clr),
    .state(st0), .out(out0), .step_cnt(cnt0), .err(err0)
  );

  mealy_table_fsm #(.N_STATES(3), .IN_W(2), .OUT_W(1), .CNT_W(3)) u_dut3 (
    .clk(clk), .reset(reset), .sw_in(sw_in), .ctrl_in(ctrl_in), .state_in(state_in),
    .cfg_we(cfg_we), .cfg_re(cfg_re), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .cfg_rdata(rd1), .cfg_rvalid(rv1), .err_clr(err_clr),
    .state(st1), .out(out1), .step_cnt(cnt1), .err(err1)
  );

  // Behavioural model: index 0 = default instance, 1 = three-state instance.
  int m_next[2][16];
  int m_outv[2][16];
  int m_st[2], m_out[2], m_cnt[2], m_rd[2];
  bit m_rv[2], m_err[2];
  int n_st[2] = '{4, 3};
  int cmod[2] = '{65536, 8};

  task automatic model_update(input int k);
    bit set_err;
    int e_next, e_out, row;
    if (reset) begin
      m_st[k]  = (state_in < n_st[k]) ? int'(state_in) : 0;
      m_err[k] = (state_in >= n_st[k]);
      m_out[k] = 0; m_cnt[k] = 0; m_rd[k] = 0; m_rv[k] = 0;
      for (int i = 0; i < 16; i++) begin
        m_next[k][i] = 0; m_outv[k][i] = 0;
      end
      return;
    end
    set_err = 0;
    row = cfg_addr / 4;
    m_rv[k] = cfg_re;
    if (cfg_re) begin
      if (row < n_st[k]) m_rd[k] = m_next[k][cfg_addr] * 2 + m_outv[k][cfg_addr];
      else begin m_rd[k] = 0; set_err = 1; end
    end
    if (ctrl_in) begin
      e_next = m_next[k][m_st[k] * 4 + sw_in];
      e_out  = m_outv[k][m_st[k] * 4 + sw_in];
      if (e_next < n_st[k]) m_st[k] = e_next;
      else begin m_st[k] = 0; set_err = 1; end
      m_out[k] = e_out;
      m_cnt[k] = (m_cnt[k] + 1) % cmod[k];
    end
    if (cfg_we) begin
      if (row < n_st[k]) begin
        m_next[k][cfg_addr] = cfg_wdata / 2;
        m_outv[k][cfg_addr] = cfg_wdata % 2;
      end else set_err = 1;
    end
    if (set_err) m_err[k] = 1;
    else if (err_clr) m_err[k] = 0;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    check("state0", 32'(st0), m_st[0]);
    check("out0", 32'(out0), m_out[0]);
    check("cnt0", 32'(cnt0), m_cnt[0]);
    check("err0", 32'(err0), 32'(m_err[0]));
    check("rvalid0", 32'(rv0), 32'(m_rv[0]));
    check("rdata0", 32'(rd0), m_rd[0]);
    check("state1", 32'(st1), m_st[1]);
    check("out1", 32'(out1), m_out[1]);
    check("cnt1", 32'(cnt1), m_cnt[1]);
    check("err1", 32'(err1), 32'(m_err[1]));
    check("rvalid1", 32'(rv1), 32'(m_rv[1]));
    check("rdata1", 32'(rd1), m_rd[1]);
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset) started = 1;
    if (started) begin
      model_update(0);
      model_update(1);
    end
    #1;
    if (started) compare_all();
  endtask

  task automatic idle();
    reset = 0; ctrl_in = 0; cfg_we = 0; cfg_re = 0; err_clr = 0;
  endtask

  task automatic do_reset(input logic [1:0] s);
    idle(); reset = 1; state_in = s; tick(); reset = 0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [2:0] d);
    idle(); cfg_we = 1; cfg_addr = a; cfg_wdata = d; tick(); cfg_we = 0;
  endtask

  task automatic rd(input logic [3:0] a);
    idle(); cfg_re = 1; cfg_addr = a; tick(); cfg_re = 0;
  endtask

  task automatic step(input logic [1:0] s);
    idle(); ctrl_in = 1; sw_in = s; tick(); ctrl_in = 0;
  endtask

  logic [2:0] prog [8];

  initial begin
    idle(); sw_in = 0; state_in = 0; cfg_addr = 0; cfg_wdata = 0;
    prog = '{3'd1, 3'd0, 3'd3, 3'd3, 3'd0, 3'd3, 3'd3, 3'd2};

    do_reset(2'd1);
    check("lit_reset_state", 32'(st0), 1);
    check("lit_reset_out", 32'(out0), 0);
    check("lit_reset_cnt", 32'(cnt0), 0);
    check("lit_reset_err", 32'(err0), 0);

    for (int i = 0; i < 8; i++) wr(4'(i), prog[i]);
    step(2'd0); check("lit_s1_state", 32'(st0), 0); check("lit_s1_out", 32'(out0), 0);
    step(2'd2); check("lit_s2_state", 32'(st0), 1); check("lit_s2_out", 32'(out0), 1);
    step(2'd3); check("lit_s3_state", 32'(st0), 1); check("lit_s3_out", 32'(out0), 0);
    step(2'd0); check("lit_s4_state", 32'(st0), 0); check("lit_s4_out", 32'(out0), 0);
    check("lit_s4_cnt", 32'(cnt0), 4);

    for (int i = 0; i < 5; i++) begin
      idle(); sw_in = 2'(i + 1); tick();
    end
    check("lit_hold_state", 32'(st0), 0);
    check("lit_hold_cnt", 32'(cnt0), 4);

    rd(4'd2);
    check("lit_rvalid", 32'(rv0), 1);
    check("lit_rdata", 32'(rd0), 3);
    idle(); tick();
    check("lit_rvalid_drop", 32'(rv0), 0);

    // Write to {1,3} coinciding with a step that reads that same entry.
    step(2'd2);
    idle(); ctrl_in = 1; sw_in = 2'd3; cfg_we = 1; cfg_addr = 4'd7; cfg_wdata = 3'd5; tick();
    check("lit_wrstep_state", 32'(st0), 1);
    check("lit_wrstep_out", 32'(out0), 0);
    step(2'd3);
    check("lit_after_state", 32'(st0), 2);
    check("lit_after_out", 32'(out0), 1);

    wr(4'd8, 3'd6);
    step(2'd0);
    check("lit_n3_state", 32'(st1), 0);
    check("lit_n3_err", 32'(err1), 1);
    idle(); err_clr = 1; tick(); err_clr = 0;
    check("lit_n3_clr", 32'(err1), 0);
    rd(4'd12);
    check("lit_n3_rdata", 32'(rd1), 0);
    check("lit_n3_rderr", 32'(err1), 1);
    do_reset(2'd3);
    check("lit_rst3_state", 32'(st1), 0);
    check("lit_rst3_err", 32'(err1), 1);
    check("lit_rst3_state4", 32'(st0), 3);

    do_reset(2'd0);
    for (int i = 0; i < 9; i++) step(2'(i));
    check("lit_wrap_cnt", 32'(cnt1), 1);
    wr(4'd5, 3'd7);
    step(2'd1);
    do_reset(2'd2);
    rd(4'd5);
    check("lit_midrst_rdata", 32'(rd0), 0);
    check("lit_midrst_state", 32'(st0), 2);

    for (int i = 0; i < 3000; i++) begin
      reset     = ($urandom_range(0, 63) == 0);
      ctrl_in   = $urandom_range(0, 1) == 1;
      cfg_we    = ($urandom_range(0, 2) == 0);
      cfg_re    = ($urandom_range(0, 2) == 0);
      err_clr   = ($urandom_range(0, 7) == 0);
      sw_in     = 2'($urandom_range(0, 3));
      state_in  = 2'($urandom_range(0, 3));
      cfg_addr  = 4'($urandom_range(0, 15));
      cfg_wdata = 3'($urandom_range(0, 7));
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
